// File: rtl/word_serial_adder_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : word_serial_adder_ctrl                                           |
// | Purpose  : N*K-bit unsigned adder built from one N-bit chunk adder,         |
// |            one chunk per cycle, with the carry held in a register.          |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module word_serial_adder_ctrl #(
    parameter int N = 3,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*K-1:0] a_in,
    input  logic [N*K-1:0] b_in,
    output logic           busy,
    output logic           done,
    output logic [N*K:0]   sum_out
);

    localparam int IDXW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N*K-1:0]   r_a;
    logic [N*K-1:0]   r_b;
    logic [N*K-1:0]   r_work;
    logic [N*K:0]     r_sum;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [N-1:0]     w_ca;
    logic [N-1:0]     w_cb;
    logic [N-1:0]     w_s;
    logic             w_c;
    logic             w_last;
    logic [N*K-1:0]   w_work_next;

    // Chunk select by index compare keeps every slice bound constant.
    always_comb begin
        w_ca = '0;
        w_cb = '0;
        for (int i = 0; i < K; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_ca = r_a[i*N +: N];
                w_cb = r_b[i*N +: N];
            end
        end
    end

    assign {w_c, w_s} = {1'b0, w_ca} + {1'b0, w_cb} + {{N{1'b0}}, r_carry};

    always_comb begin
        w_work_next = r_work;
        for (int i = 0; i < K; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_work_next[i*N +: N] = w_s;
            end
        end
    end

    assign w_last = (r_idx == IDXW'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_c;
                    if (w_last) begin
                        r_sum   <= {w_c, w_work_next};
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign sum_out = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_word_serial_adder_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_word_serial_adder_ctrl                                        |
// | Purpose  : directed self-checking bench, N=3 with K=4 and K=1 instances.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_word_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] a_in;
    logic [11:0] b_in;
    logic        busy;
    logic        done;
    logic [12:0] sum_out;

    logic        start1;
    logic [2:0]  a1;
    logic [2:0]  b1;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;

    int          n_cmp;
    int          n_err;
    logic [12:0] last_sum;

    word_serial_adder_ctrl #(.N(3), .K(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out)
    );

    word_serial_adder_ctrl #(.N(3), .K(1)) u_dut_k1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .busy    (busy1),
        .done    (done1),
        .sum_out (sum1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 13'd0) begin
            n_err++;
            $display("FAIL reset_k4: busy=%b done=%b sum=%h, required 0 0 0000", busy, done, sum_out);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 4'd0) begin
            n_err++;
            $display("FAIL reset_k1: busy=%b done=%b sum=%h, required 0 0 0", busy1, done1, sum1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        last_sum = 13'd0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; a_in = 12'd5; b_in = 12'd4;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || sum_out !== last_sum) begin
                n_err++;
                $display("FAIL basic_run[%0d]: busy=%b done=%b sum=%h, required 1 0 %h", i, busy, done, sum_out, last_sum);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || sum_out !== 13'd9) begin
            n_err++;
            $display("FAIL basic_done: busy=%b done=%b sum=%h, required 0 1 0009", busy, done, sum_out);
        end
        last_sum = 13'd9;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 13'd9) begin
            n_err++;
            $display("FAIL basic_hold: busy=%b done=%b sum=%h, required 0 0 0009", busy, done, sum_out);
        end
    endtask

    task automatic test_carry_ripple();
        @(negedge clk);
        start = 1'b1; a_in = 12'hFFF; b_in = 12'h001;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || sum_out !== last_sum) begin
                n_err++;
                $display("FAIL ripple_run[%0d]: busy=%b done=%b sum=%h, required 1 0 %h", i, busy, done, sum_out, last_sum);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || sum_out !== 13'h1000) begin
            n_err++;
            $display("FAIL ripple_done: done=%b sum=%h, required 1 1000", done, sum_out);
        end
        last_sum = 13'h1000;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        logic [11:0] va [2];
        logic [11:0] vb [2];
        logic [12:0] vs [2];
        va[0] = 12'hABC; vb[0] = 12'h123; vs[0] = 13'h0BDF;
        va[1] = 12'h800; vb[1] = 12'h800; vs[1] = 13'h1000;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            start = 1'b1; a_in = va[v]; b_in = vb[v];
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            n_cmp++;
            if (done !== 1'b1 || sum_out !== vs[v]) begin
                n_err++;
                $display("FAIL pattern[%0d]: done=%b sum=%h, required 1 %h", v, done, sum_out, vs[v]);
            end
            last_sum = vs[v];
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        int extra_done;
        @(negedge clk);
        start = 1'b1; a_in = 12'd7; b_in = 12'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 12'd1; b_in = 12'd7;
        @(negedge clk);
        start = 1'b0; a_in = 12'hFFF; b_in = 12'hFFF;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || sum_out !== last_sum) begin
            n_err++;
            $display("FAIL busy_start_run: busy=%b sum=%h, required 1 %h", busy, sum_out, last_sum);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || sum_out !== 13'd9) begin
            n_err++;
            $display("FAIL busy_start_done: done=%b sum=%h, required 1 0009", done, sum_out);
        end
        last_sum   = 13'd9;
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra_done++;
        end
        n_cmp++;
        if (extra_done != 0 || sum_out !== 13'd9) begin
            n_err++;
            $display("FAIL busy_start_ignored: active_cycles=%0d sum=%h, required 0 0009", extra_done, sum_out);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        start = 1'b1; a_in = 12'h0F0; b_in = 12'h00F;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 13'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h, required 0 0 0000", busy, done, sum_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || sum_out !== 13'd0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL reset_no_done: active_cycles=%0d, required 0", stray);
        end
        last_sum = 13'd0;
        @(negedge clk);
        start = 1'b1; a_in = 12'd3; b_in = 12'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || sum_out !== 13'd6) begin
            n_err++;
            $display("FAIL reset_recover: done=%b sum=%h, required 1 0006", done, sum_out);
        end
        last_sum = 13'd6;
        @(negedge clk);
    endtask

    task automatic test_k1_back_to_back();
        logic exp_busy;
        logic exp_done;
        @(negedge clk);
        start1 = 1'b1; a1 = 3'd7; b1 = 3'd7;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            exp_busy = ((j % 3) == 0);
            exp_done = ((j % 3) == 1);
            n_cmp++;
            if (busy1 !== exp_busy || done1 !== exp_done) begin
                n_err++;
                $display("FAIL k1_seq[%0d]: busy=%b done=%b, required %b %b", j, busy1, done1, exp_busy, exp_done);
            end
            if (j == 0) begin
                n_cmp++;
                if (sum1 !== 4'h0) begin
                    n_err++;
                    $display("FAIL k1_pre: sum=%h, required 0", sum1);
                end
            end
            if (exp_done) begin
                n_cmp++;
                if (sum1 !== 4'hE) begin
                    n_err++;
                    $display("FAIL k1_sum[%0d]: sum=%h, required e", j, sum1);
                end
            end
        end
        start1 = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_patterns();
        test_start_while_busy();
        test_reset_mid();
        test_k1_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
